csa_resolve_serial: RTL and testbench

CSA_RESOLVE_SERIAL -- requirements
Module: csa_resolve_serial

---
 rtl/csa_resolve_serial.sv | 133 +++++++++++++
 tb/tb_csa_resolve_serial.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_resolve_serial.sv
// Bit-serial carry-save to binary resolver.
// Accepts one redundant-form pair (sum, carry) and ripples it LSB-first through
// a single full adder, one result bit per clock, then holds the binary result
// until the downstream side takes it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a pair; in_ready high
// RUN   | resolving bit idx (0..WIDTH) of the latched pair
// DONE  | out_result valid, held until out_ready
module csa_resolve_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_result,
  output logic             busy
);

  // Index must reach WIDTH, so it needs enough bits for WIDTH+1 positions.
  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Latched operands aligned to a common WIDTH+1 bit grid:
  // s_q has a zero MSB, c_q is the carry vector pre-shifted by one.
  logic [WIDTH:0]   s_q;
  logic [WIDTH:0]   c_q;
  logic [IW-1:0]    idx;
  logic             cy;
  // Low result bits, shifted in LSB first; after WIDTH steps bit 0 is r[0].
  logic [WIDTH-1:0] r_q;

  logic accept;
  logic last_bit;
  logic bit_s;
  logic bit_c;
  logic sum_bit;
  logic cy_nxt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (idx == LAST_IDX) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy      = 1'b0;
      end
    endcase
  end

  // One full-adder slice on the currently selected bit position.
  always_comb begin
    accept   = in_valid && (state == IDLE);
    last_bit = (state == RUN) && (idx == LAST_IDX);
    bit_s    = s_q[idx];
    bit_c    = c_q[idx];
    sum_bit  = bit_s ^ bit_c ^ cy;
    cy_nxt   = (bit_s & bit_c) | (bit_s & cy) | (bit_c & cy);
  end

  // Operand capture, serial accumulation and result load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= '0;
      c_q        <= '0;
      idx        <= '0;
      cy         <= 1'b0;
      r_q        <= '0;
      out_result <= '0;
    end else if (accept) begin
      s_q <= {1'b0, in_sum};
      c_q <= {in_carry, 1'b0};
      idx <= '0;
      cy  <= 1'b0;
      r_q <= '0;
    end else if (state == RUN) begin
      cy <= cy_nxt;
      if (last_bit) begin
        // Top two bits come straight from the final slice; out_result is
        // only ever written here so it stays frozen through RUN and IDLE.
        out_result <= {cy_nxt, sum_bit, r_q};
      end else begin
        r_q <= {sum_bit, r_q[WIDTH-1:1]};
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_csa_resolve_serial.sv
module tb_csa_resolve_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] in_sum, in_carry;
  logic [5:0] out_result;

  logic       v8_in_valid, v8_in_ready, v8_out_valid, v8_out_ready, v8_busy;
  logic [7:0] v8_in_sum, v8_in_carry;
  logic [9:0] v8_out_result;

  csa_resolve_serial #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  csa_resolve_serial #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (v8_in_valid),
    .in_ready   (v8_in_ready),
    .in_sum     (v8_in_sum),
    .in_carry   (v8_in_carry),
    .out_valid  (v8_out_valid),
    .out_ready  (v8_out_ready),
    .out_result (v8_out_result),
    .busy       (v8_busy)
  );

  typedef struct {
    logic [3:0] s;
    logic [3:0] c;
    logic [5:0] exp;
  } vec_t;

  vec_t       tbl[9];
  logic [5:0] q4[$];
  logic [9:0] q8[$];
  logic [5:0] last4;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send4(input logic [3:0] s, input logic [3:0] c, input logic [5:0] exp);
    int n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("send4_ready", in_ready, 1);
    in_sum   = s;
    in_carry = c;
    in_valid = 1'b1;
    q4.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv4(input string name, input int hold);
    int         lat = 0;
    logic [5:0] e;
    check({name, "_busy"}, busy, 1);
    check({name, "_inready_low"}, in_ready, 0);
    check({name, "_frozen_run"}, out_result, last4);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, 5);
    if (q4.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: result appeared with nothing expected", name);
    end else begin
      e = q4.pop_front();
      for (int i = 0; i < hold; i++) begin
        in_sum   = 4'(in_sum + 4'd3);
        in_carry = ~in_carry;
        in_valid = 1'b1;
        @(negedge clk);
        check({name, "_hold_result"}, out_result, e);
        check({name, "_hold_valid"}, out_valid, 1);
        check({name, "_hold_inready"}, in_ready, 0);
      end
      in_valid = 1'b0;
      check({name, "_result"}, out_result, e);
      last4 = e;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_valid_dropped"}, out_valid, 0);
    check({name, "_idle_again"}, in_ready, 1);
  endtask

  task automatic run8(input logic [7:0] s, input logic [7:0] c);
    int         n = 0;
    int         lat = 0;
    logic [9:0] e;
    while (!v8_in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    v8_in_sum   = s;
    v8_in_carry = c;
    v8_in_valid = 1'b1;
    q8.push_back({2'b00, s} + {1'b0, c, 1'b0});
    @(negedge clk);
    v8_in_valid = 1'b0;
    while (!v8_out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("w8_latency", lat, 9);
    if (q8.size() == 0) begin
      total++;
      bad++;
      $display("FAIL w8_result: result appeared with nothing expected");
    end else begin
      e = q8.pop_front();
      check("w8_result", v8_out_result, e);
    end
    v8_out_ready = 1'b1;
    @(negedge clk);
    v8_out_ready = 1'b0;
  endtask

  initial begin
    int         seen;
    int         k;
    int         cyc;
    int         acc[4];
    logic [5:0] e;
    logic [3:0] rs, rc;

    tbl[0] = '{4'b0000, 4'b1111, 6'd30};
    tbl[1] = '{4'b0111, 4'b1111, 6'd37};
    tbl[2] = '{4'b1111, 4'b1111, 6'd45};
    tbl[3] = '{4'b0000, 4'b0000, 6'd0};
    tbl[4] = '{4'b0001, 4'b0000, 6'd1};
    tbl[5] = '{4'b0000, 4'b0001, 6'd2};
    tbl[6] = '{4'b1010, 4'b0101, 6'd20};
    tbl[7] = '{4'b0011, 4'b0110, 6'd15};
    tbl[8] = '{4'b1000, 4'b1000, 6'd24};

    rst_n        = 1'b0;
    in_valid     = 1'b1;
    out_ready    = 1'b0;
    in_sum       = 4'b0101;
    in_carry     = 4'b0011;
    v8_in_valid  = 1'b0;
    v8_out_ready = 1'b0;
    v8_in_sum    = '0;
    v8_in_carry  = '0;
    last4        = '0;

    #1;
    check("rst_inready", in_ready, 1);
    check("rst_outvalid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", out_result, 0);
    check("rst_w8_valid", v8_out_valid, 0);
    // A clock edge with in_valid high while in reset must not accept.
    @(negedge clk);
    check("rst_no_accept", busy, 0);
    check("rst_inready_held", in_ready, 1);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      send4(tbl[i].s, tbl[i].c, tbl[i].exp);
      recv4("tbl", 0);
    end

    // Output held in DONE with upstream noise.
    send4(4'b1111, 4'b0000, 6'd15);
    recv4("hold", 10);

    // Asynchronous reset in the middle of RUN.
    send4(4'b0111, 4'b1111, 6'd37);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_result", out_result, 0);
    check("arst_busy", busy, 0);
    check("arst_valid", out_valid, 0);
    check("arst_inready", in_ready, 1);
    #1 rst_n = 1'b1;
    q4.delete();
    last4 = '0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    check("arst_no_pulse", seen, 0);
    send4(4'b0000, 4'b0000, 6'd0);
    recv4("after_rst", 0);

    // Back-to-back stream with both handshakes held high.
    k   = 0;
    cyc = 0;
    in_sum    = tbl[0].s;
    in_carry  = tbl[0].c;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while ((k < 4 || q4.size() > 0) && cyc < 100) begin
      if (out_valid) begin
        if (q4.size() > 0) begin
          e = q4.pop_front();
          check("b2b_result", out_result, e);
        end else begin
          total++;
          bad++;
          $display("FAIL b2b_result: unexpected output %0d", out_result);
        end
      end
      if (in_ready && k < 4) begin
        q4.push_back(tbl[k].exp);
        acc[k] = cyc;
        k++;
      end else if (!in_ready) begin
        if (k < 4) begin
          in_sum   = tbl[k].s;
          in_carry = tbl[k].c;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_accepts", k, 4);
    check("b2b_drained", q4.size(), 0);
    for (int i = 1; i < 4; i++) begin
      if (i < k) check("b2b_spacing", acc[i] - acc[i-1], 7);
    end
    q4.delete();
    last4 = tbl[3].exp;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      rs = 4'($urandom_range(0, 15));
      rc = 4'($urandom_range(0, 15));
      send4(rs, rc, {2'b00, rs} + {1'b0, rc, 1'b0});
      recv4("rand4", 0);
    end

    run8(8'hff, 8'hff);
    run8(8'h00, 8'h00);
    for (int i = 0; i < 16; i++) begin
      run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
